// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIVIDE,
    FIX,
    DONE
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift, trial subtract, restore.
module div_step #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             neg;

  always_comb begin
    shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    // extra top bit catches a borrow from the trial subtract
    diff    = {1'b0, shifted} - {2'b00, dsr_i};
    neg     = diff[WIDTH+1];
    rem_o   = neg ? shifted : diff[WIDTH:0];
    quo_o   = {quo_i[WIDTH-2:0], ~neg};
  end

endmodule

// File: rtl/divider_n.sv
// Multi-cycle signed/unsigned restoring divider with
// zero-divisor and signed-overflow short paths.
module divider_n
  import divider_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] rem_lo;
  logic             q_neg, r_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (prem_q),
    .quo_i (qr_q),
    .dsr_i (dmag_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    prem_d  = prem_q;
    qr_d    = qr_q;
    dmag_d  = dmag_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    rem_lo  = prem_q[WIDTH-1:0];
    q_neg   = sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg   = sm_q & a_q[WIDTH-1];
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          sm_d    = signed_mode;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (b_q == '0) begin
          dbz_d   = 1'b1;
          quo_d   = '1;
          rem_d   = a_q;
          state_d = DONE;
        end else if (sm_q && a_q == MOST_NEG && b_q == '1) begin
          ovf_d   = 1'b1;
          quo_d   = a_q;
          rem_d   = '0;
          state_d = DONE;
        end else begin
          // most-negative magnitude still fits as unsigned
          qr_d    = (sm_q && a_q[WIDTH-1]) ? -a_q : a_q;
          dmag_d  = (sm_q && b_q[WIDTH-1]) ? -b_q : b_q;
          prem_d  = '0;
          cnt_d   = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        prem_d = step_rem;
        qr_d   = step_quo;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quo_d   = q_neg ? -qr_q : qr_q;
        rem_d   = r_neg ? -rem_lo : rem_lo;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      prem_q  <= '0;
      qr_q    <= '0;
      dmag_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      prem_q  <= prem_d;
      qr_q    <= qr_d;
      dmag_q  <= dmag_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_n.sv
// Directed scoreboard bench for divider_n at WIDTH=5.
module tb_divider_n;

  localparam int W = 5;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  divider_n #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit sm,
                                 input logic [W-1:0] dd,
                                 input logic [W-1:0] ds);
    exp_t e;
    logic signed [W-1:0] sd;
    logic signed [W-1:0] ss;
    sd    = dd;
    ss    = ds;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = W + 3;
    if (ds == 0) begin
      e.q   = '1;
      e.r   = dd;
      e.dbz = 1'b1;
      e.lat = 2;
    end else if (sm && dd == 5'b10000 && ds == 5'b11111) begin
      e.q   = dd;
      e.r   = '0;
      e.ovf = 1'b1;
      e.lat = 2;
    end else if (sm) begin
      e.q = sd / ss;
      e.r = sd % ss;
    end else begin
      e.q = dd / ds;
      e.r = dd % ds;
    end
    return e;
  endfunction

  task automatic run_op(input bit sm,
                        input logic [W-1:0] dd,
                        input logic [W-1:0] ds,
                        input bit glitch);
    exp_t e;
    int   nd;
    int   first;
    nd    = 0;
    first = -10;
    sb.push_back(model(sm, dd, ds));
    @(negedge clk);
    start       = 1'b1;
    signed_mode = sm;
    dividend    = dd;
    divisor     = ds;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start       = 1'b0;
        signed_mode = ~sm;
        dividend    = W'($urandom);
        divisor     = W'($urandom);
        chk("busy_after_start", busy, 1);
      end
      if (glitch && k == 3) begin
        start    = 1'b1;
        dividend = 5'd30;
        divisor  = 5'd3;
      end
      if (glitch && k == 4) start = 1'b0;
      if (k == first + 1) begin
        chk("done_one_cycle", done, 0);
        chk("hold_quotient", quotient, e.q);
        chk("hold_remainder", remainder, e.r);
      end
      if (done) begin
        nd++;
        if (nd == 1) begin
          first = k;
          e = sb.pop_front();
          chk("latency", k, e.lat);
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dbz);
          chk("overflow", overflow, e.ovf);
          chk("busy_in_done", busy, 1);
        end
      end
    end
    chk("done_pulses", nd, 1);
    chk("idle_busy", busy, 0);
    if (nd == 0 && sb.size() > 0) void'(sb.pop_front());
  endtask

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(1'b0, 5'd23, 5'd5, 1'b0);
    run_op(1'b0, 5'd13, 5'd0, 1'b0);
    run_op(1'b1, 5'b11001, 5'b00010, 1'b0);
    run_op(1'b0, 5'b11001, 5'b00010, 1'b0);
    run_op(1'b1, 5'b10000, 5'b11111, 1'b0);
    run_op(1'b0, 5'b10000, 5'b11111, 1'b0);
    run_op(1'b1, 5'd7, 5'b11101, 1'b0);
    run_op(1'b1, 5'b10000, 5'd3, 1'b0);
    run_op(1'b1, 5'b10000, 5'd1, 1'b0);
    run_op(1'b0, 5'd31, 5'd1, 1'b0);
    run_op(1'b1, 5'b11001, 5'd0, 1'b0);
    run_op(1'b0, 5'd23, 5'd5, 1'b1);

    // abort mid-DIVIDE; last result (4 r 3) is still held
    @(negedge clk);
    start       = 1'b1;
    signed_mode = 1'b0;
    dividend    = 5'd23;
    divisor     = 5'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    chk("abort_ovf", overflow, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(1'b0, 5'd3, 5'd7, 1'b0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_n.md
DIVIDER_N -- requirements
Module: divider_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the operand and result width in bits; WIDTH SHALL be at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a request, sampled only in IDLE.
REQ-005 The block SHALL have port signed_mode, input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned; it is sampled with start.
REQ-006 The block SHALL have port dividend, input, WIDTH bits, sampled with start.
REQ-007 The block SHALL have port divisor, input, WIDTH bits, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: a registered one-cycle pulse, high exactly while in DONE.
REQ-010 The block SHALL have port quotient, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have port remainder, output, WIDTH bits: the registered result.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: a registered flag for the last operation.
REQ-013 The block SHALL have port overflow, output, 1 bit: a registered flag for the last operation, set only for signed most-negative / -1.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, DIVIDE, FIX and DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL latch the operands and mode, then enter LOAD, clearing div_by_zero and overflow.
REQ-016 In LOAD, for divisor==0, the block SHALL set div_by_zero=1, quotient=all ones and remainder=dividend, then enter DONE.
REQ-017 In LOAD, for signed_mode with dividend=100..0 and divisor=all ones, the block SHALL set overflow=1, quotient=dividend and remainder=0, then enter DONE.
REQ-018 In LOAD otherwise, the block SHALL take operand magnitudes (absolute value in signed mode), clear the WIDTH+1-bit partial remainder and the iteration counter, then enter DIVIDE.
REQ-019 In DIVIDE, each cycle SHALL perform one restoring step:
  - shift {partial remainder, quotient register} left by one;
  - subtract the divisor magnitude;
  - if the result is negative, restore and set quotient bit 0 to 0, else keep the result and set bit 0 to 1.
  - After exactly WIDTH steps the block SHALL enter FIX.
REQ-020 In FIX, the block SHALL apply signed correction: the quotient is negated when operand signs differ, and the remainder takes the sign of the dividend, so that division truncates toward zero. The corrected results SHALL be written to quotient and remainder, then the block SHALL enter DONE.
REQ-021 DONE SHALL last one cycle and then return to IDLE.
REQ-022 Latency, counted from the edge sampling start to the first cycle with done=1:
  - normal path: WIDTH+3 cycles;
  - zero-divisor or overflow path: 2 cycles.
REQ-023 start SHALL be ignored in LOAD, DIVIDE, FIX and DONE; the latched operands SHALL NOT change mid-operation.
REQ-024 quotient, remainder and the flags SHALL hold their values from DONE until the next accepted start reaches LOAD or FIX.
REQ-025 Unsigned mode SHALL never assert overflow.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0 and the counter to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse; after release, the block SHALL accept start on the first edge.

Structure
REQ-028 Package divider_pkg SHALL hold the FSM state enumeration and the counter-width function (clog2 of WIDTH+1).
REQ-029 One combinational sub-module, div_step, SHALL implement a single shift-subtract-restore iteration, parametrised by WIDTH.

Verification
REQ-030 The bench SHALL cover these scenarios, all with WIDTH=5:
  - Unsigned 23/5: quotient=4, remainder=3, done after 8 cycles, flags=0.
  - 13/0: quotient=31, remainder=13, div_by_zero=1, done after 2 cycles.
  - Signed -7/2 (11001/00010): quotient=11101 (-3), remainder=11111 (-1). The same operands unsigned (25/2): quotient=12, remainder=1.
  - Signed -16/-1 (10000/11111): overflow=1, quotient=10000, remainder=0, done after 2 cycles.
  - start with different operands pulsed during DIVIDE: the result is unchanged, and exactly one done pulse occurs.
  - rst_n low during DIVIDE: busy=0 and all outputs 0 immediately, no done; then 3/7 gives quotient=0, remainder=3.
